cordic_iter_ctrl: RTL and testbench

Iterative CORDIC rotation-mode sequencer that time-shares one external saturating 16-bit add/sub unit (`ADD_SUB`) across the x, y and z updates of every micro-rotation. It accepts a start request with an initial vector and angle, runs `ITER` iterations with shift-and-add steps and arctangent constants from an internal ROM, and returns the rotated vector and residual angle with a done pulse. It sits between the CORDIC top-level command logic and the shared arithmetic unit.

---
 rtl/cordic_iter_ctrl_if.sv | 31 +++
 rtl/cordic_iter_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_iter_ctrl_if.sv
// Command, result and shared add/sub signals of the CORDIC iteration sequencer.
// The controller uses the slave modport; the command source and ALU side use master.
`default_nettype none

interface cordic_iter_ctrl_if;
  logic               Start;
  logic signed [15:0] X_in;
  logic signed [15:0] Y_in;
  logic signed [15:0] Z_in;
  logic               Busy;
  logic               Done;
  logic signed [15:0] X_out;
  logic signed [15:0] Y_out;
  logic signed [15:0] Z_out;
  logic signed [15:0] Alu_a;
  logic signed [15:0] Alu_b;
  logic               Alu_enable;
  logic signed [15:0] Alu_res;

  modport slave (
    input  Start, X_in, Y_in, Z_in, Alu_res,
    output Busy, Done, X_out, Y_out, Z_out, Alu_a, Alu_b, Alu_enable
  );

  modport master (
    output Start, X_in, Y_in, Z_in, Alu_res,
    input  Busy, Done, X_out, Y_out, Z_out, Alu_a, Alu_b, Alu_enable
  );
endinterface

`default_nettype wire

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC rotation sequencer sharing one registered saturating add/sub unit.
// Optional quadrant pre-rotation enabled by defining CORDIC_QUAD_EXT_EN.
`default_nettype none

module cordic_iter_ctrl #(
  parameter int ITER = 14
) (
  input  wire logic         Clk,
  input  wire logic         Reset,
  cordic_iter_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] S_X  = 3'd1;
  localparam logic [2:0] S_Y  = 3'd2;
  localparam logic [2:0] S_Z  = 3'd3;
  localparam logic [2:0] S_W  = 3'd4;
`ifdef CORDIC_QUAD_EXT_EN
  localparam logic [2:0] S_PRE  = 3'd5;
  localparam logic [2:0] S_PREW = 3'd6;
  localparam logic signed [15:0] HALF_PI     = 16'sd12868;
  localparam logic signed [15:0] NEG_HALF_PI = -16'sd12868;
`endif
  localparam logic [3:0] LAST = 4'(ITER - 1);

  logic [2:0]         state_q, state_d;
  logic [3:0]         i_q, i_d;
  logic signed [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [15:0] xn_q, xn_d, yn_q, yn_d;
  logic signed [15:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
  logic               done_q, done_d;
  logic               dir;

  function automatic logic signed [15:0] atan_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_rom = 16'sd6434;
      4'd1:    atan_rom = 16'sd3798;
      4'd2:    atan_rom = 16'sd2007;
      4'd3:    atan_rom = 16'sd1019;
      4'd4:    atan_rom = 16'sd511;
      4'd5:    atan_rom = 16'sd256;
      4'd6:    atan_rom = 16'sd128;
      4'd7:    atan_rom = 16'sd64;
      4'd8:    atan_rom = 16'sd32;
      4'd9:    atan_rom = 16'sd16;
      4'd10:   atan_rom = 16'sd8;
      4'd11:   atan_rom = 16'sd4;
      4'd12:   atan_rom = 16'sd2;
      4'd13:   atan_rom = 16'sd1;
      default: atan_rom = 16'sd0;
    endcase
  endfunction

`ifdef CORDIC_QUAD_EXT_EN
  function automatic logic signed [15:0] neg_sat(input logic signed [15:0] v);
    neg_sat = (v == -16'sd32768) ? 16'sd32767 : -v;
  endfunction
`endif

  // Rotation direction is fixed per iteration because z only changes in S_W.
  assign dir = ~z_q[15];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xn_q    <= '0;
      yn_q    <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xn_q    <= xn_d;
      yn_q    <= yn_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xn_d    = xn_q;
    yn_d    = yn_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          x_d = bus.X_in;
          y_d = bus.Y_in;
          z_d = bus.Z_in;
          i_d = '0;
`ifdef CORDIC_QUAD_EXT_EN
          state_d = S_PRE;
`else
          state_d = S_X;
`endif
        end
      end
      S_X: state_d = S_Y;
      S_Y: begin
        xn_d    = bus.Alu_res;
        state_d = S_Z;
      end
      S_Z: begin
        yn_d    = bus.Alu_res;
        state_d = S_W;
      end
      S_W: begin
        x_d = xn_q;
        y_d = yn_q;
        z_d = bus.Alu_res;
        if (i_q == LAST) begin
          xo_d    = xn_q;
          yo_d    = yn_q;
          zo_d    = bus.Alu_res;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          i_d     = i_q + 4'd1;
          state_d = S_X;
        end
      end
`ifdef CORDIC_QUAD_EXT_EN
      S_PRE: begin
        if (z_q > HALF_PI) begin
          x_d = neg_sat(y_q);
          y_d = x_q;
        end else if (z_q < NEG_HALF_PI) begin
          x_d = y_q;
          y_d = neg_sat(x_q);
        end
        state_d = S_PREW;
      end
      S_PREW: begin
        z_d     = bus.Alu_res;
        state_d = S_X;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.Alu_a      = '0;
    bus.Alu_b      = '0;
    bus.Alu_enable = 1'b0;
    case (state_q)
      S_X: begin
        bus.Alu_a      = x_q;
        bus.Alu_b      = y_q >>> i_q;
        bus.Alu_enable = ~dir;
      end
      S_Y: begin
        bus.Alu_a      = y_q;
        bus.Alu_b      = x_q >>> i_q;
        bus.Alu_enable = dir;
      end
      S_Z: begin
        bus.Alu_a      = z_q;
        bus.Alu_b      = atan_rom(i_q);
        bus.Alu_enable = ~dir;
      end
`ifdef CORDIC_QUAD_EXT_EN
      S_PRE: begin
        bus.Alu_a = z_q;
        if (z_q > HALF_PI) begin
          bus.Alu_b      = HALF_PI;
          bus.Alu_enable = 1'b0;
        end else if (z_q < NEG_HALF_PI) begin
          bus.Alu_b      = HALF_PI;
          bus.Alu_enable = 1'b1;
        end else begin
          bus.Alu_b      = '0;
          bus.Alu_enable = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign bus.Busy  = (state_q != IDLE);
  assign bus.Done  = done_q;
  assign bus.X_out = xo_q;
  assign bus.Y_out = yo_q;
  assign bus.Z_out = zo_q;

endmodule

`default_nettype wire

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench for cordic_iter_ctrl: ALU model, reference CORDIC model and Done scoreboard.
`default_nettype none

module tb_cordic_iter_ctrl;
  localparam int ITER = 14;
`ifdef CORDIC_QUAD_EXT_EN
  localparam int PRE = 2;
`else
  localparam int PRE = 0;
`endif
  localparam int L = 4 * ITER + PRE;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  cordic_iter_ctrl_if bus();

  cordic_iter_ctrl #(.ITER(ITER)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int done_seen = 0;
  logic prev_done = 1'b0;
  int atan_t [16] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0, 0};

  typedef struct {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
    int due;
  } exp_t;
  exp_t q[$];

  function automatic logic signed [15:0] sat16(input int v);
    if (v > 32767) return 16'sd32767;
    if (v < -32768) return -16'sd32768;
    return 16'(v);
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  // Shared saturating add/sub unit, one-cycle registered result.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) bus.Alu_res <= '0;
    else bus.Alu_res <= sat16(bus.Alu_enable ? int'(bus.Alu_a) + int'(bus.Alu_b)
                                             : int'(bus.Alu_a) - int'(bus.Alu_b));
  end

  function automatic void model(input int x0, input int y0, input int z0,
                                output logic signed [15:0] xr, output logic signed [15:0] yr,
                                output logic signed [15:0] zr);
    int x, y, z, xn, yn;
    x = x0; y = y0; z = z0;
`ifdef CORDIC_QUAD_EXT_EN
    if (z0 > 12868) begin
      x = sat16(-y0); y = x0; z = sat16(z0 - 12868);
    end else if (z0 < -12868) begin
      x = y0; y = sat16(-x0); z = sat16(z0 + 12868);
    end
`endif
    for (int i = 0; i < ITER; i++) begin
      if (z >= 0) begin
        xn = sat16(x - (y >>> i));
        yn = sat16(y + (x >>> i));
        z  = sat16(z - atan_t[i]);
      end else begin
        xn = sat16(x + (y >>> i));
        yn = sat16(y - (x >>> i));
        z  = sat16(z + atan_t[i]);
      end
      x = xn; y = yn;
    end
    xr = 16'(x); yr = 16'(y); zr = 16'(z);
  endfunction

  always @(negedge Clk) begin
    if (bus.Done === 1'b1) begin
      exp_t e;
      done_seen++;
      tests++;
      if (prev_done !== 1'b0) begin
        fails++;
        $display("FAIL done_width: Done high on consecutive cycles at cycle %0d", cyc);
      end
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: Done at cycle %0d with no job outstanding", cyc);
      end else begin
        e = q.pop_front();
        if (bus.X_out !== e.x || bus.Y_out !== e.y || bus.Z_out !== e.z || cyc != e.due) begin
          fails++;
          $display("FAIL result: got x=%0d y=%0d z=%0d cyc=%0d, expected x=%0d y=%0d z=%0d cyc=%0d",
                   bus.X_out, bus.Y_out, bus.Z_out, cyc, e.x, e.y, e.z, e.due);
        end
      end
    end
    prev_done = bus.Done;
  end

  // Call away from a rising edge; returns 1ns after the edge that samples Start.
  task automatic start_job(input int x, input int y, input int z, input bit accept);
    exp_t e;
    bus.X_in  = 16'(x);
    bus.Y_in  = 16'(y);
    bus.Z_in  = 16'(z);
    bus.Start = 1'b1;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    if (accept) begin
      model(x, y, z, e.x, e.y, e.z);
      e.due = cyc + L;
      q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d jobs outstanding after %0d cycles, expected 0", q.size(), budget);
      q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    tests++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.X_out !== 16'sd0 || bus.Y_out !== 16'sd0 ||
        bus.Z_out !== 16'sd0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b x=%0d y=%0d z=%0d, expected all 0",
               bus.Busy, bus.Done, bus.X_out, bus.Y_out, bus.Z_out);
    end
    tests++;
    if (bus.Alu_a !== 16'sd0 || bus.Alu_b !== 16'sd0 || bus.Alu_enable !== 1'b0) begin
      fails++;
      $display("FAIL reset_alu: a=%0d b=%0d en=%b, expected 0 0 0", bus.Alu_a, bus.Alu_b, bus.Alu_enable);
    end
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_gain();
    int dx, dy, dz;
    @(negedge Clk);
    start_job(4975, 0, 0, 1'b1);
    tests++;
    if (bus.Busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_rise: busy=%b after start edge, expected 1", bus.Busy);
    end
    wait_drain(L + 10);
    dx = int'(bus.X_out) - 8192; dy = int'(bus.Y_out); dz = int'(bus.Z_out);
    tests++;
    if (dx > 8 || dx < -8 || dy > 8 || dy < -8 || dz > 2 || dz < -2) begin
      fails++;
      $display("FAIL gain: x=%0d y=%0d z=%0d, expected 8192+-8 0+-8 0+-2", bus.X_out, bus.Y_out, bus.Z_out);
    end
    tests++;
    if (bus.Busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_fall: busy=%b after done, expected 0", bus.Busy);
    end
  endtask

  task automatic test_pi4();
    int dx, dy;
    @(negedge Clk);
    start_job(4975, 0, 6434, 1'b1);
    wait_drain(L + 10);
    dx = int'(bus.X_out) - 5793; dy = int'(bus.Y_out) - 5793;
    tests++;
    if (dx > 8 || dx < -8 || dy > 8 || dy < -8) begin
      fails++;
      $display("FAIL pi4: x=%0d y=%0d, expected 5793+-8 5793+-8", bus.X_out, bus.Y_out);
    end
  endtask

  task automatic test_saturation();
    @(negedge Clk);
    start_job(32767, 32767, 0, 1'b1);
    repeat (PRE) @(posedge Clk);
    @(negedge Clk);
    tests++;
    if (bus.Alu_a !== 16'sd32767 || bus.Alu_b !== 16'sd32767 || bus.Alu_enable !== 1'b0) begin
      fails++;
      $display("FAIL sat_issue_x: a=%0d b=%0d en=%b, expected 32767 32767 0", bus.Alu_a, bus.Alu_b, bus.Alu_enable);
    end
    @(negedge Clk);
    tests++;
    if (bus.Alu_a !== 16'sd32767 || bus.Alu_b !== 16'sd32767 || bus.Alu_enable !== 1'b1) begin
      fails++;
      $display("FAIL sat_issue_y: a=%0d b=%0d en=%b, expected 32767 32767 1", bus.Alu_a, bus.Alu_b, bus.Alu_enable);
    end
    @(negedge Clk);
    tests++;
    if (bus.Alu_a !== 16'sd0 || bus.Alu_b !== 16'sd6434 || bus.Alu_enable !== 1'b0) begin
      fails++;
      $display("FAIL sat_issue_z: a=%0d b=%0d en=%b, expected 0 6434 0", bus.Alu_a, bus.Alu_b, bus.Alu_enable);
    end
    @(negedge Clk);
    tests++;
    if (bus.Alu_a !== 16'sd0 || bus.Alu_b !== 16'sd0 || bus.Alu_enable !== 1'b0) begin
      fails++;
      $display("FAIL sat_idle_w: a=%0d b=%0d en=%b, expected 0 0 0", bus.Alu_a, bus.Alu_b, bus.Alu_enable);
    end
    wait_drain(L + 10);
  endtask

  task automatic test_back_to_back();
    int d0 = done_seen;
    int n = 0;
    @(negedge Clk);
    start_job(1000, 2000, 3000, 1'b1);
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    start_job(-500, 700, -4000, 1'b0);
    tests++;
    if (bus.Busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_hold: busy=%b during job, expected 1", bus.Busy);
    end
    @(negedge Clk);
    while (bus.Done !== 1'b1 && n < L + 10) begin
      @(negedge Clk);
      n++;
    end
    start_job(-3000, 1500, -5000, 1'b1);
    wait_drain(L + 10);
    repeat (3) @(negedge Clk);
    tests++;
    if (done_seen - d0 != 2) begin
      fails++;
      $display("FAIL done_count: %0d Done pulses, expected 2", done_seen - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    @(negedge Clk);
    start_job(4975, 0, 0, 1'b1);
    d0 = done_seen;
    repeat (19) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    tests++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.X_out !== 16'sd0 || bus.Y_out !== 16'sd0 ||
        bus.Z_out !== 16'sd0 || bus.Alu_a !== 16'sd0 || bus.Alu_b !== 16'sd0) begin
      fails++;
      $display("FAIL async_reset: busy=%b done=%b x=%0d y=%0d z=%0d a=%0d b=%0d, expected all 0",
               bus.Busy, bus.Done, bus.X_out, bus.Y_out, bus.Z_out, bus.Alu_a, bus.Alu_b);
    end
    q.delete();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (L + 5) @(negedge Clk);
    tests++;
    if (done_seen != d0) begin
      fails++;
      $display("FAIL aborted_done: %0d Done pulses after reset, expected 0", done_seen - d0);
    end
    start_job(2000, -1000, -7000, 1'b1);
    wait_drain(L + 10);
  endtask

`ifdef CORDIC_QUAD_EXT_EN
  task automatic test_quad_ext();
    int dx, dy;
    @(negedge Clk);
    start_job(4975, 0, 16384, 1'b1);
    wait_drain(L + 10);
    dx = int'(bus.X_out) + 3409; dy = int'(bus.Y_out) - 7449;
    tests++;
    if (dx > 12 || dx < -12 || dy > 12 || dy < -12) begin
      fails++;
      $display("FAIL quad_ext: x=%0d y=%0d, expected -3409+-12 7449+-12", bus.X_out, bus.Y_out);
    end
    @(negedge Clk);
    start_job(-32768, 3000, -16000, 1'b1);
    wait_drain(L + 10);
  endtask
`endif

  initial begin
    bus.Start = 1'b0;
    bus.X_in  = '0;
    bus.Y_in  = '0;
    bus.Z_in  = '0;
    test_reset();
    test_gain();
    test_pi4();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
`ifdef CORDIC_QUAD_EXT_EN
    test_quad_ext();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
